// File: rtl/iob_mul_shiftadd.sv
// Sequential shift-and-add multiplier: one partial-product step per enabled clock,
// signed or unsigned per operation, result {acc,mq} qualified by done.
module iob_mul_shiftadd #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sign,
    output logic                  done,
    input  logic [DATA_W-1:0]     multiplicand,
    input  logic [DATA_W-1:0]     multiplier,
    output logic [2*DATA_W-1:0]   product
);

    localparam int PC_W = $clog2(DATA_W + 3) + 1;
    localparam logic [PC_W-1:0] PC_LOAD = {PC_W{1'b0}};
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(DATA_W);
    localparam logic [PC_W-1:0] PC_SIGN = PC_W'(DATA_W + 1);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

    typedef enum logic [1:0] {
        PH_LOAD = 2'd0,
        PH_ITER = 2'd1,
        PH_SIGN = 2'd2,
        PH_HOLD = 2'd3
    } phase_e;

    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   mq_q, mq_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic                res_neg_q, res_neg_d;
    logic                done_q, done_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    phase_e              phase_s;
    logic [DATA_W:0]     sum_s;
    logic [2*DATA_W-1:0] full_s;

    // Magnitude as an unsigned DATA_W-bit value, so the most negative input maps correctly.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        if (x[DATA_W-1]) begin
            r = ~x + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Decode the step counter into a phase.
    always_comb begin
        phase_s = PH_HOLD;
        if (pc_q == PC_LOAD) begin
            phase_s = PH_LOAD;
        end else if (pc_q <= PC_LAST) begin
            phase_s = PH_ITER;
        end else if (pc_q == PC_SIGN) begin
            phase_s = PH_SIGN;
        end else begin
            phase_s = PH_HOLD;
        end
    end

    // Next-state datapath for each step.
    always_comb begin
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        res_neg_d = res_neg_q;
        done_d    = done_q;
        pc_d      = pc_q;
        sum_s     = {(DATA_W+1){1'b0}};
        full_s    = {acc_q, mq_q};
        case (phase_s)
            PH_LOAD: begin
                acc_d = {DATA_W{1'b0}};
                if (sign) begin
                    mcand_d   = abs_val(multiplicand);
                    mq_d      = abs_val(multiplier);
                    res_neg_d = multiplicand[DATA_W-1] ^ multiplier[DATA_W-1];
                end else begin
                    mcand_d   = multiplicand;
                    mq_d      = multiplier;
                    res_neg_d = 1'b0;
                end
                pc_d = pc_q + PC_ONE;
            end
            PH_ITER: begin
                // Carry out of the add becomes the new acc msb as the pair shifts right.
                sum_s = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : {(DATA_W+1){1'b0}});
                {acc_d, mq_d} = {sum_s, mq_q[DATA_W-1:1]};
                pc_d = pc_q + PC_ONE;
            end
            PH_SIGN: begin
                if (res_neg_q) begin
                    full_s = ~{acc_q, mq_q} + {{(2*DATA_W-1){1'b0}}, 1'b1};
                end else begin
                    full_s = {acc_q, mq_q};
                end
                {acc_d, mq_d} = full_s;
                done_d = 1'b1;
                pc_d   = pc_q + PC_ONE;
            end
            PH_HOLD: begin
                pc_d = pc_q;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // State registers; reset or a dropped enable abandons the operation.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            acc_q     <= {DATA_W{1'b0}};
            mq_q      <= {DATA_W{1'b0}};
            mcand_q   <= {DATA_W{1'b0}};
            res_neg_q <= 1'b0;
            done_q    <= 1'b0;
            pc_q      <= {PC_W{1'b0}};
        end else begin
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            res_neg_q <= res_neg_d;
            done_q    <= done_d;
            pc_q      <= pc_d;
        end
    end

    assign done    = done_q;
    assign product = {acc_q, mq_q};

endmodule

// File: tb/tb_iob_mul_shiftadd.sv
// Scoreboard bench for iob_mul_shiftadd: 8-bit and 32-bit instances, directed vectors
// plus golden-model 32-bit vectors, latency, hold, clear and reset checks.
module tb_iob_mul_shiftadd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en8 = 1'b0, sign8 = 1'b0, done8;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0;
    logic [15:0] p8;
    logic        en32 = 1'b0, sign32 = 1'b0, done32;
    logic [31:0] a32 = 32'd0, b32 = 32'd0;
    logic [63:0] p32;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cnt8 = 0, cnt32 = 0;
    logic [15:0] q8[$];
    logic [63:0] q32[$];
    logic [15:0] cur8 = 16'd0;
    logic [63:0] cur32 = 64'd0;
    logic prev8 = 1'b0, prev32 = 1'b0;

    iob_mul_shiftadd #(.DATA_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .sign(sign8), .done(done8),
        .multiplicand(a8), .multiplier(b8), .product(p8)
    );

    iob_mul_shiftadd #(.DATA_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .en(en32), .sign(sign32), .done(done32),
        .multiplicand(a32), .multiplier(b32), .product(p32)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Enabled-edge counters used for latency checks.
    always @(posedge clk) begin
        if (!rst_n || !en8) cnt8 <= 0; else cnt8 <= cnt8 + 1;
        if (!rst_n || !en32) cnt32 <= 0; else cnt32 <= cnt32 + 1;
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (done8) begin
            if (!prev8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_done8", 64'(done8), 64'd0);
                end else begin
                    cur8 = q8.pop_front();
                    chk("product8", 64'(p8), 64'(cur8));
                    chk("latency8", 64'(cnt8), 64'd10);
                end
            end else begin
                chk("hold8", 64'(p8), 64'(cur8));
            end
        end
        prev8 = done8;
    end

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (done32) begin
            if (!prev32) begin
                if (q32.size() == 0) begin
                    chk("unexpected_done32", 64'(done32), 64'd0);
                end else begin
                    cur32 = q32.pop_front();
                    chk("product32", p32, cur32);
                    chk("latency32", 64'(cnt32), 64'd34);
                end
            end else begin
                chk("hold32", p32, cur32);
            end
        end
        prev32 = done32;
    end

    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit scramble);
        bit seen = 1'b0;
        @(negedge clk);
        sign8 = s; a8 = a; b8 = b; en8 = 1'b1;
        q8.push_back(exp);
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
            else if (scramble) begin
                a8 = 8'($urandom); b8 = 8'($urandom); sign8 = ~sign8;
            end
        end
        if (!seen) begin
            chk("timeout8", 64'(done8), 64'd1);
            if (q8.size() > 0) void'(q8.pop_front());
        end
        repeat (2) @(negedge clk);
        en8 = 1'b0;
        @(negedge clk);
        chk("clear8_done", 64'(done8), 64'd0);
        chk("clear8_product", 64'(p8), 64'd0);
    endtask

    task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        bit seen = 1'b0;
        @(negedge clk);
        sign32 = s; a32 = a; b32 = b; en32 = 1'b1;
        q32.push_back(exp);
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done32) seen = 1'b1;
        end
        if (!seen) begin
            chk("timeout32", 64'(done32), 64'd1);
            if (q32.size() > 0) void'(q32.pop_front());
        end
        @(negedge clk);
        en32 = 1'b0;
        @(negedge clk);
        chk("clear32_done", 64'(done32), 64'd0);
    endtask

    function automatic logic [63:0] model32(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] r;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            r = 64'(sa * sb);
        end else begin
            r = {32'd0, a} * {32'd0, b};
        end
        return r;
    endfunction

    initial begin
        logic [31:0] ra, rb;
        logic rs;
        bit seen;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_done8", 64'(done8), 64'd0);
        chk("reset_product8", 64'(p8), 64'd0);
        chk("reset_done32", 64'(done32), 64'd0);
        chk("reset_product32", p32, 64'd0);
        rst_n = 1'b1;

        run8(1'b0, 8'd200, 8'd150, 16'h7530, 1'b0);
        run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
        run8(1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0);
        run8(1'b1, 8'hF9, 8'd5, 16'hFFDD, 1'b0);
        run8(1'b1, 8'h80, 8'h80, 16'h4000, 1'b0);
        run8(1'b0, 8'h80, 8'h80, 16'h4000, 1'b0);
        run8(1'b1, 8'h7F, 8'h80, 16'hC080, 1'b0);
        run8(1'b0, 8'h80, 8'hFF, 16'h7F80, 1'b0);
        run8(1'b1, 8'h00, 8'hFF, 16'h0000, 1'b0);
        run8(1'b1, 8'hF9, 8'd5, 16'hFFDD, 1'b1);
        run8(1'b0, 8'd200, 8'd150, 16'h7530, 1'b1);

        // Enable dropped after edge 5 abandons the operation.
        @(negedge clk);
        sign8 = 1'b0; a8 = 8'd200; b8 = 8'd150; en8 = 1'b1;
        repeat (5) @(negedge clk);
        en8 = 1'b0;
        @(negedge clk);
        chk("abort_done8", 64'(done8), 64'd0);
        chk("abort_product8", 64'(p8), 64'd0);
        run8(1'b0, 8'd13, 8'd11, 16'h008F, 1'b0);

        // One-edge reset mid-operation with en held high, then restart.
        @(negedge clk);
        sign8 = 1'b1; a8 = 8'hF9; b8 = 8'd5; en8 = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_done8", 64'(done8), 64'd0);
        chk("midreset_product8", 64'(p8), 64'd0);
        rst_n = 1'b1;
        q8.push_back(16'hFFDD);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        if (!seen) begin
            chk("timeout8_restart", 64'(done8), 64'd1);
            if (q8.size() > 0) void'(q8.pop_front());
        end
        en8 = 1'b0;
        @(negedge clk);

        run32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        run32(1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000);
        run32(1'b1, 32'hFFFFFFFF, 32'h7FFFFFFF, 64'hFFFFFFFF80000001);
        run32(1'b1, 32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000);
        run32(1'b0, 32'd123456789, 32'd1000, 64'd123456789000);
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            run32(rs, ra, rb, model32(rs, ra, rb));
        end

        chk("queue8_empty", 64'(q8.size()), 64'd0);
        chk("queue32_empty", 64'(q32.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
